med_window_3x3: RTL

- Streaming 3x3 neighbourhood generator that sits directly upstream of the combinational median stage.
- Accepts one 8-bit grayscale pixel per accepted beat in raster order.
- Buffers the two previous image rows internally.
- Presents the nine pixels of each fully-interior 3x3 window as s1..s9, together with a one-cycle valid pulse, so the median stage's output is meaningful exactly when win_valid is high.

---
 rtl/med_window_3x3.sv | 112 +++++++++++
 1 files changed

// File: rtl/med_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two row line buffers plus a 3x3 shift window.
// Flags each fully interior window with a one-cycle win_valid pulse.
module med_window_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] s1,
    output logic [7:0] s2,
    output logic [7:0] s3,
    output logic [7:0] s4,
    output logic [7:0] s5,
    output logic [7:0] s6,
    output logic [7:0] s7,
    output logic [7:0] s8,
    output logic [7:0] s9,
    output logic       win_valid,
    output logic       win_eof
);
    // Handshake: a beat is accepted on every rising edge with pix_valid high; there is
    // no ready, so the source never stalls. sof is only honoured on an accepted beat.

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb_a [IMG_W];
    logic [7:0]    r_lb_b [IMG_W];
    logic [7:0]    r_s    [9];

    logic [CW-1:0] w_c;
    logic [RW-1:0] w_r;
    logic          w_c_last;
    logic          w_r_last;
    logic [7:0]    w_top;
    logic [7:0]    w_mid;

    // sof relocates the current beat to (0,0) without waiting for the counters.
    always_comb begin
        w_c      = sof ? '0 : r_col;
        w_r      = sof ? '0 : r_row;
        w_c_last = (w_c == C_LAST);
        w_r_last = (w_r == R_LAST);
        w_top    = r_lb_a[w_c];
        w_mid    = r_lb_b[w_c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_c_last) begin
                r_col <= '0;
                r_row <= w_r_last ? '0 : w_r + 1'b1;
            end else begin
                r_col <= w_c + 1'b1;
                r_row <= w_r;
            end
        end
    end

    // Line buffers carry no reset: gating keeps their stale contents from being flagged.
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            r_lb_a[w_c] <= w_mid;
            r_lb_b[w_c] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_s[i] <= '0;
            win_valid <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= pix_valid && (w_r >= R_TWO) && (w_c >= C_TWO);
            win_eof   <= pix_valid && w_r_last && w_c_last;
            if (pix_valid) begin
                r_s[0] <= r_s[1];
                r_s[1] <= r_s[2];
                r_s[2] <= w_top;
                r_s[3] <= r_s[4];
                r_s[4] <= r_s[5];
                r_s[5] <= w_mid;
                r_s[6] <= r_s[7];
                r_s[7] <= r_s[8];
                r_s[8] <= pix_in;
            end
        end
    end

    assign s1 = r_s[0];
    assign s2 = r_s[1];
    assign s3 = r_s[2];
    assign s4 = r_s[3];
    assign s5 = r_s[4];
    assign s6 = r_s[5];
    assign s7 = r_s[6];
    assign s8 = r_s[7];
    assign s9 = r_s[8];

endmodule
